// File: rtl/pippo_wbctrl_if.sv
// Write-back stage handshake bundle: instruction/LSU status in, GPR write port and pulses out.
// The slave modport is the controller; the master modport is whoever drives the WB stage.
interface pippo_wbctrl_if;
  logic       wb_valid;
  logic [1:0] wb_src;
  logic       wb_upd;
  logic [4:0] wb_rd;
  logic [4:0] wb_ra;
  logic       wb_freeze;
  logic       lsu_ack;
  logic       lsu_err;
  logic [1:0] mux_sel;
  logic       gpr_we;
  logic [4:0] gpr_waddr;
  logic       wb_stall;
  logic       wb_done;
  logic       wb_abort;

  modport master (
    output wb_valid, wb_src, wb_upd, wb_rd, wb_ra, wb_freeze, lsu_ack, lsu_err,
    input  mux_sel, gpr_we, gpr_waddr, wb_stall, wb_done, wb_abort
  );

  modport slave (
    input  wb_valid, wb_src, wb_upd, wb_rd, wb_ra, wb_freeze, lsu_ack, lsu_err,
    output mux_sel, gpr_we, gpr_waddr, wb_stall, wb_done, wb_abort
  );
endinterface

// File: rtl/pippo_wbctrl.sv
// Write-back controller: sequences GPR writes for ALU/SPR/LSU results, waits on load data
// with a timeout, and issues the second rA write of update-form loads/stores.
module pippo_wbctrl #(
  parameter logic [7:0] LSU_TIMEOUT = 8'd255
) (
  input logic           clk,
  input logic           rst_n,
  pippo_wbctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StWaitLsu, StUpd} state_e;

  localparam logic [1:0] SrcLsu = 2'b01;
  localparam logic [1:0] SrcEa  = 2'b11;
  localparam logic [7:0] TimeoutLast = LSU_TIMEOUT - 8'd1;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] src_q, src_d;
  logic       upd_q, upd_d;
  logic [4:0] rd_q, rd_d;
  logic [4:0] ra_q, ra_d;

  logic [1:0] mux_sel;
  logic       gpr_we;
  logic [4:0] gpr_waddr;
  logic       wb_stall;
  logic       wb_done;
  logic       wb_abort;
  logic       accept;
  logic       upd_eff;

  assign accept  = (state_q == StIdle) && bus.wb_valid && !bus.wb_freeze;
  // Update form degenerates to a single write when rA is r0 or aliases rD.
  assign upd_eff = bus.wb_upd && (bus.wb_ra != 5'd0) && (bus.wb_ra != bus.wb_rd);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    src_d     = src_q;
    upd_d     = upd_q;
    rd_d      = rd_q;
    ra_d      = ra_q;
    mux_sel   = 2'b00;
    gpr_we    = 1'b0;
    gpr_waddr = 5'd0;
    wb_stall  = 1'b0;
    wb_done   = 1'b0;
    wb_abort  = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          mux_sel = bus.wb_src;
          src_d   = bus.wb_src;
          upd_d   = upd_eff;
          rd_d    = bus.wb_rd;
          ra_d    = bus.wb_ra;
          if (bus.wb_src == SrcLsu && bus.lsu_err) begin
            wb_abort = 1'b1;
          end else if (bus.wb_src != SrcLsu || bus.lsu_ack) begin
            gpr_we    = 1'b1;
            gpr_waddr = bus.wb_rd;
            if (upd_eff) begin
              wb_stall = 1'b1;
              state_d  = StUpd;
            end else begin
              wb_done = 1'b1;
            end
          end else begin
            wb_stall = 1'b1;
            cnt_d    = 8'd0;
            state_d  = StWaitLsu;
          end
        end
      end

      StWaitLsu: begin
        wb_stall = 1'b1;
        mux_sel  = src_q;
        if (!bus.wb_freeze) begin
          if (bus.lsu_err) begin
            wb_abort = 1'b1;
            state_d  = StIdle;
          end else if (bus.lsu_ack) begin
            gpr_we    = 1'b1;
            gpr_waddr = rd_q;
            if (upd_q) begin
              state_d = StUpd;
            end else begin
              wb_done = 1'b1;
              state_d = StIdle;
            end
          end else if (cnt_q == TimeoutLast) begin
            wb_abort = 1'b1;
            state_d  = StIdle;
          end else if (cnt_q != 8'hff) begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      StUpd: begin
        mux_sel = SrcEa;
        if (!bus.wb_freeze) begin
          gpr_we    = 1'b1;
          gpr_waddr = ra_q;
          wb_done   = 1'b1;
          state_d   = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      src_q   <= 2'b00;
      upd_q   <= 1'b0;
      rd_q    <= 5'd0;
      ra_q    <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      upd_q   <= upd_d;
      rd_q    <= rd_d;
      ra_q    <= ra_d;
    end
  end

  assign bus.mux_sel   = mux_sel;
  assign bus.gpr_we    = gpr_we;
  assign bus.gpr_waddr = gpr_waddr;
  assign bus.wb_stall  = wb_stall;
  assign bus.wb_done   = wb_done;
  assign bus.wb_abort  = wb_abort;

endmodule
